// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - command-driven Wishbone single-cycle master
//
// Takes register commands from a valid/ready channel and queues them in a small FIFO.
// It runs one Wishbone read or write cycle per command. Each command produces a
// one-cycle response strobe carrying the read data or a timeout error.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready = FIFO not full)
//   cmd_we/addr/data/sel command payload
//   rsp_valid           one-cycle response strobe
//   rsp_data            read data (0 for writes and errors)
//   rsp_err             stb timed out without ack
//   busy                FIFO non-empty or bus cycle in progress
//   cyc/stb/we/addr/sel/data_wr  Wishbone master outputs
//   data_rd/ack         Wishbone slave responses
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_SIZE   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int IDLE_X     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [SEL_SIZE-1:0]   cmd_sel,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  cyc,
  output logic                  stb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_SIZE-1:0]   sel,
  output logic [DATA_WIDTH-1:0] data_wr,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  ack
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 1 + ADDR_WIDTH + SEL_SIZE + DATA_WIDTH;

  // Value parked on the address/data/select lines while no cycle is open.
  localparam logic [ADDR_WIDTH-1:0] ADDR_IDLE = (IDLE_X != 0) ? {ADDR_WIDTH{1'bx}} : '0;
  localparam logic [SEL_SIZE-1:0]   SEL_IDLE  = (IDLE_X != 0) ? {SEL_SIZE{1'bx}}   : '0;
  localparam logic [DATA_WIDTH-1:0] DATA_IDLE = (IDLE_X != 0) ? {DATA_WIDTH{1'bx}} : '0;

  typedef enum logic [1:0] {S_IDLE, S_CYC, S_STB, S_GAP} state_t;

  state_t                state, state_d;
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         tmo_cnt, tmo_cnt_d;
  logic                  push, pop;
  logic                  head_we;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [SEL_SIZE-1:0]   head_sel;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [SEL_SIZE-1:0]   sel_d;
  logic [DATA_WIDTH-1:0] data_wr_d, rsp_data_d;

  assign cmd_ready = (count != CW'(FIFO_DEPTH));
  assign busy      = (count != '0) || (state != S_IDLE);
  assign push      = cmd_valid && cmd_ready;
  // The FIFO head is consumed only as a cycle is opened.
  assign pop       = (state == S_IDLE) && (count != '0);
  assign {head_we, head_addr, head_sel, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_sel, cmd_data};
    end
  end

  always_comb begin
    state_d     = state;
    tmo_cnt_d   = tmo_cnt;
    cyc_d       = cyc;
    stb_d       = stb;
    we_d        = we;
    addr_d      = addr;
    sel_d       = sel;
    data_wr_d   = data_wr;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_d   = S_CYC;
          cyc_d     = 1'b1;
          we_d      = head_we;
          addr_d    = head_addr;
          sel_d     = head_sel;
          data_wr_d = head_data;
        end
      end
      S_CYC: begin
        state_d   = S_STB;
        stb_d     = 1'b1;
        tmo_cnt_d = '0;
      end
      S_STB: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (ack) begin
          state_d     = S_GAP;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we ? '0 : data_rd;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_d     = S_GAP;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      S_GAP: begin
        state_d   = S_IDLE;
        cyc_d     = 1'b0;
        we_d      = 1'b0;
        addr_d    = ADDR_IDLE;
        sel_d     = SEL_IDLE;
        data_wr_d = DATA_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cyc       <= 1'b0;
      stb       <= 1'b0;
      we        <= 1'b0;
      addr      <= ADDR_IDLE;
      sel       <= SEL_IDLE;
      data_wr   <= DATA_IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      tmo_cnt   <= tmo_cnt_d;
      cyc       <= cyc_d;
      stb       <= stb_d;
      we        <= we_d;
      addr      <= addr_d;
      sel       <= sel_d;
      data_wr   <= data_wr_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - randomized self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data;
  logic        cyc, stb, we;
  logic [7:0]  addr;
  logic [3:0]  sel;
  logic [31:0] data_wr, data_rd;
  logic        ack;

  wb_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .cyc(cyc), .stb(stb), .we(we), .addr(addr), .sel(sel), .data_wr(data_wr),
    .data_rd(data_rd), .ack(ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state: accepted commands in order, plus slave behaviour knobs.
  cmd_t        exp_q[$];
  int          lat_q[$];
  int          lat_lo = 0, lat_hi = 0;
  logic        spur_en = 1'b0;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = '0;
  logic        mon_abort = 1'b1;

  // Monitor/slave state.
  logic        in_txn = 1'b0, prev_cyc = 1'b0, prev_stb = 1'b0, prev_rsp = 1'b0;
  logic        stable_ok;
  cmd_t        cur;
  int          lat, stb_cnt, rsp_seen;
  logic [31:0] rd_val;
  int          n_done = 0, n_err_rsp = 0;
  logic [31:0] last_rsp_data = '0;

  // Slave lat = number of stb-high cycles before the cycle in which ack is driven.
  // Expected: acked if lat+1 <= TIMEOUT stb cycles, otherwise error after TIMEOUT cycles.
  always @(negedge clk) begin
    if (mon_abort) begin
      in_txn   = 1'b0;
      prev_cyc = 1'b0;
      prev_stb = 1'b0;
      prev_rsp = 1'b0;
      stb_cnt  = 0;
      ack      = 1'b0;
      exp_q.delete();
    end else begin
      if (!in_txn) check("rsp_outside_cycle", rsp_valid, 1'b0);
      if (in_txn && !cyc) begin
        check("one_rsp_per_cyc", rsp_seen, 1);
        check("fields_stable", stable_ok, 1'b1);
        check("stb_low_before_cyc_fall", prev_stb, 1'b0);
        check("cyc_fall_after_rsp", prev_rsp, 1'b1);
        in_txn = 1'b0;
        n_done++;
      end
      if (cyc && !prev_cyc) begin
        check("cmd_queued_at_cyc", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("cyc_fields", {we, addr, sel, data_wr}, cur);
          check("stb_after_cyc", stb, 1'b0);
          in_txn    = 1'b1;
          stable_ok = 1'b1;
          stb_cnt   = 0;
          rsp_seen  = 0;
          lat       = (lat_q.size() != 0) ? lat_q.pop_front() : $urandom_range(lat_hi, lat_lo);
          rd_val    = rd_fixed_en ? rd_fixed : $urandom;
        end
      end
      if (in_txn) begin
        if ({we, addr, sel, data_wr} !== cur) stable_ok = 1'b0;
        if (stb) stb_cnt++;
        if (rsp_valid) begin
          logic ok;
          ok = (lat + 1 <= TIMEOUT);
          rsp_seen++;
          check("rsp_err", rsp_err, !ok);
          check("rsp_data", rsp_data, (ok && !cur.we) ? rd_val : 32'h0);
          check("stb_len", stb_cnt, ok ? lat + 1 : TIMEOUT);
          check("rsp_phase", {cyc, stb}, 2'b10);
          if (rsp_err) n_err_rsp++;
          last_rsp_data = rsp_data;
        end
      end
      if (stb) begin
        ack     = (stb_cnt == lat + 1);
        data_rd = ack ? rd_val : $urandom;
      end else begin
        ack     = spur_en;
        data_rd = $urandom;
      end
      prev_cyc = cyc;
      prev_stb = stb;
      prev_rsp = rsp_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    int guard = 0;
    cmd_we = w; cmd_addr = a; cmd_data = d; cmd_sel = s;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("push_accepted", cmd_ready, 1'b1);
    if (cmd_ready) begin
      @(posedge clk);
      exp_q.push_back({w, a, s, d});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || cyc) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("idle_reached", {busy, cyc}, 2'b00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_sel = '0;
    data_rd = '0; ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc_stb_we", {cyc, stb, we}, 3'b000);
    check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy_ready", {busy, cmd_ready}, 2'b01);
    rst = 1'b0;
    mon_abort = 1'b0;
    @(negedge clk);

    // 1: write, slave acks on second stb cycle
    lat_lo = 1; lat_hi = 1;
    push_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    check("t1_cyc_e0", cyc, 1'b0);
    @(negedge clk);
    check("t1_cyc_e1", {cyc, stb}, 2'b10);
    @(negedge clk);
    check("t1_stb_e2", {cyc, stb, we, addr}, {3'b111, 8'h04});
    wait_idle();

    // 2: read with single-cycle ack
    lat_lo = 0; lat_hi = 0; rd_fixed_en = 1'b1; rd_fixed = 32'h0000_00A5;
    push_cmd(1'b0, 8'h10, 32'h0, 4'hF);
    wait_idle();
    check("t2_rdata", last_rsp_data, 32'hA5);
    rd_fixed_en = 1'b0;

    // 3: five back-to-back commands with a slow slave fill the FIFO
    lat_lo = 5; lat_hi = 5;
    for (int i = 0; i < 5; i++) push_cmd(i[0], 8'(8'h20 + i), $urandom, 4'(i + 1));
    check("t3_full_ready_low", cmd_ready, 1'b0);
    push_cmd(1'b0, 8'h30, 32'h0, 4'h3);
    wait_idle();

    // 4: read never acked times out, the next command proceeds
    n0 = n_err_rsp;
    lat_q.push_back(1000);
    lat_q.push_back(0);
    push_cmd(1'b0, 8'h44, 32'h0, 4'hF);
    push_cmd(1'b1, 8'h48, 32'h12345678, 4'h5);
    wait_idle();
    check("t4_one_error", n_err_rsp - n0, 1);

    // timeout boundary: ack on the last allowed cycle versus one cycle late
    n0 = n_err_rsp;
    lat_q.push_back(TIMEOUT - 1);
    lat_q.push_back(TIMEOUT);
    push_cmd(1'b0, 8'h50, 32'h0, 4'hF);
    push_cmd(1'b0, 8'h54, 32'h0, 4'hF);
    wait_idle();
    check("tmo_boundary_errors", n_err_rsp - n0, 1);

    // 5: reset while stb high with two commands queued
    lat_lo = 30; lat_hi = 30;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 8'(8'h60 + i), $urandom, 4'hF);
    check("t5_stb_before_rst", stb, 1'b1);
    mon_abort = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_bus_after_rst", {cyc, stb}, 2'b00);
    check("t5_status_after_rst", {busy, rsp_valid, cmd_ready}, 3'b001);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_quiet_after_rst", {rsp_valid, cyc, busy}, 3'b000);
    end
    mon_abort = 1'b0;

    // 6: ack asserted outside STB is ignored
    n0 = n_done;
    spur_en = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_idle_busy", {busy, cyc}, 2'b00);
    check("t6_no_rsp", n_done, n0);
    lat_lo = 3; lat_hi = 3;
    push_cmd(1'b1, 8'h70, 32'hCAFEF00D, 4'hC);
    wait_idle();
    check("t6_one_completion", n_done - n0, 1);
    spur_en = 1'b0;

    // randomized traffic
    lat_lo = 0; lat_hi = 20;
    for (int i = 0; i < 40; i++) begin
      spur_en = 1'($urandom);
      push_cmd(1'($urandom), 8'($urandom), $urandom, 4'($urandom));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_idle();
    spur_en = 1'b0;
    check("all_cmds_done", exp_q.size(), 0);
    check("no_open_txn", in_txn, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Command-driven Wishbone master that sequences single read/write cycles to the SPI master core's register slave.
- Accepts register commands over a valid/ready channel and buffers them in a small FIFO.
- Issues one Wishbone cycle per command, obeying the bus-level rules the wb_uvc interface checkers enforce.
- Returns read data or error status on a one-cycle response strobe; sits between test/firmware-sequencer logic and the SPI core's Wishbone port.

Parameters:
- ADDR_WIDTH, 8: Wishbone address width (matches WB_ADDR_WIDTH).
- DATA_WIDTH, 32: Wishbone data width (matches WB_DATA_WIDTH).
- SEL_SIZE, 4: byte-select width (matches WB_SEL_SIZE).
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT, 16: cycles stb may stay high without ack before abort; ≥2.
- IDLE_X, 1: 1 = addr/data_wr/sel driven all-X while cyc low; 0 = driven 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_data  in  DATA_WIDTH  write data
- cmd_sel  in  SEL_SIZE  byte selects
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_err  out  1  timeout abort
- busy  out  1  FIFO non-empty or cycle in progress
- cyc  out  1  Wishbone cycle
- stb  out  1  Wishbone strobe
- we  out  1  Wishbone write enable
- addr  out  ADDR_WIDTH  Wishbone address
- sel  out  SEL_SIZE  Wishbone select
- data_wr  out  DATA_WIDTH  Wishbone write data
- data_rd  in  DATA_WIDTH  Wishbone read data
- ack  in  1  Wishbone acknowledge

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values:
  - cyc=0, stb=0, we=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, cmd_ready=1.
  - addr/sel/data_wr: X if IDLE_X=1, else 0.
  - FIFO emptied; timeout counter cleared.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = !full.
  - Pop on the IDLE→CYC transition only.
  - Simultaneous push and pop when full: not possible, because ready is deasserted at full.
  - Simultaneous push and pop otherwise: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: cyc=0, stb=0. FIFO non-empty at edge → CYC; pop entry, latch we/addr/sel/data_wr, set cyc=1.
  - CYC: cyc=1, stb=0 for exactly one cycle; next edge → STB, stb=1. Guarantees stb rises ≥1 cycle after cyc.
  - STB:
    - cyc=1, stb=1; counter increments each cycle.
    - ack sampled high at edge → GAP. At that edge: stb=0, rsp_valid=1, rsp_err=0; rsp_data=data_rd if read, else 0.
    - Counter reaches TIMEOUT-1 without ack → GAP with stb=0, rsp_valid=1, rsp_err=1, rsp_data=0.
  - GAP: cyc=1, stb=0 for one cycle; rsp_valid deasserts. Next edge → IDLE, cyc=0, addr/sel/data_wr return to idle value.
- Bus invariants:
  - we/addr/sel/data_wr stable from cyc rise through cyc fall.
  - stb falls ≥1 cycle before cyc falls.
  - cyc stays low ≥1 cycle between commands.
- Latency: command pushed at edge E0 → cyc high after E1, stb after E2. Ack at Ek → rsp_valid during cycle after Ek, cyc low after Ek+1, next cyc earliest after Ek+2.
- ack while not in STB is ignored. ack held >1 cycle is not re-counted.
- rst mid-cycle: next edge forces reset values; queued and in-flight commands are dropped; no response is issued.
- busy = FIFO non-empty || state≠IDLE.

Test Plan:
1. Write cmd addr=0x04, data=0xDEADBEEF, sel=0xF; slave acks 2 cycles after stb rise → cyc@E1, stb@E2–E4, we=1, addr=0x04 stable; one rsp_valid, rsp_err=0, rsp_data=0; cyc falls one cycle after stb.
2. Read addr=0x10; slave returns data_rd=0x0000_00A5 with single-cycle ack → rsp_data=0xA5, rsp_err=0, exactly one rsp_valid.
3. Push 5 commands back-to-back, FIFO_DEPTH=4, slave slow → cmd_ready low once 4 queued; all 5 issued in order; each cyc separated by ≥1 low cycle.
4. Read with ack never asserted → stb high exactly 16 cycles; rsp_err=1, rsp_data=0; cyc drops next cycle; following queued command proceeds normally.
5. Assert rst for 1 cycle while stb=1 with 2 commands queued → cyc=stb=0 next cycle; busy=0; no rsp_valid; cmd_ready=1.
6. Spurious ack in IDLE and during CYC state → no response, no state change; normal completion on later ack.
